// File: rtl/ram_sp_arbiter.sv
// Two-requester round-robin sequencer driving a single-port RAM (async read, sync write, shared data bus).
// Latency: access cycle follows the handshake edge; read data and rvalid appear one edge after that.
// Backpressure: ready is offered only in IDLE, so there is at most one access per two cycles, with a bus-idle turnaround.
module ram_sp_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,

    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_address,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    last_grant_q;
    logic                    owner_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    ram_cs_q;
    logic                    ram_we_q;
    logic                    ram_oe_q;
    logic [ADDR_WIDTH-1:0]   ram_address_q;
    logic                    rvalid0_q;
    logic                    rvalid1_q;
    logic [DATA_WIDTH-1:0]   rdata0_q;
    logic [DATA_WIDTH-1:0]   rdata1_q;

    // Next-grant selection and the command it carries.
    logic                    grant_vld_d;
    logic                    grant_id_d;
    logic                    hs_d;
    logic                    cmd_we_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_d;
    logic [DATA_WIDTH-1:0]   cmd_wdata_d;

    // Round-robin pick: a lone requester always wins; on a tie the one not granted last wins.
    always_comb begin
        grant_vld_d = req0_valid | req1_valid;
        grant_id_d  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id_d = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id_d = 1'b1;
        end
        hs_d        = (state_q == IDLE) && rst_n && grant_vld_d;
        cmd_we_d    = grant_id_d ? req1_we    : req0_we;
        cmd_addr_d  = grant_id_d ? req1_addr  : req0_addr;
        cmd_wdata_d = grant_id_d ? req1_wdata : req0_wdata;
    end

    assign req0_ready = hs_d && !grant_id_d;
    assign req1_ready = hs_d &&  grant_id_d;

    // Sequencer: IDLE -> WR|RD -> IDLE, with all RAM controls and responses registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            wdata_q       <= '0;
            ram_cs_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_oe_q      <= 1'b0;
            ram_address_q <= '0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hs_d) begin
                        owner_q       <= grant_id_d;
                        last_grant_q  <= grant_id_d;
                        ram_address_q <= cmd_addr_d;
                        wdata_q       <= cmd_wdata_d;
                        ram_cs_q      <= 1'b1;
                        ram_we_q      <= cmd_we_d;
                        ram_oe_q      <= ~cmd_we_d;
                        state_q       <= cmd_we_d ? WR : RD;
                    end
                end
                WR: begin
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    state_q  <= IDLE;
                end
                RD: begin
                    if (owner_q) begin
                        rdata1_q  <= ram_data;
                        rvalid1_q <= 1'b1;
                    end else begin
                        rdata0_q  <= ram_data;
                        rvalid0_q <= 1'b1;
                    end
                    ram_cs_q <= 1'b0;
                    ram_oe_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    ram_oe_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign ram_cs      = ram_cs_q;
    assign ram_we      = ram_we_q;
    assign ram_oe      = ram_oe_q;
    assign ram_address = ram_address_q;
    assign req0_rvalid = rvalid0_q;
    assign req1_rvalid = rvalid1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;

    // Bus drive comes straight from the state register, so the enable cannot glitch.
    assign ram_data = (state_q == WR) ? wdata_q : 'z;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Directed and constrained-random bench for ram_sp_arbiter with an async-read / sync-write RAM model.
// Latency: checks are taken 1ns after each rising edge, or on the falling edge in the random phase.
// Backpressure: requesters hold valid until accepted; waits are bounded.
module tb_ram_sp_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_we, req1_valid, req1_we;
    logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic       req0_ready, req1_ready, req0_rvalid, req1_rvalid;
    logic [7:0] req0_rdata, req1_rdata;
    logic       ram_cs, ram_we, ram_oe;
    logic [7:0] ram_address;
    wire  [7:0] ram_data;

    logic [7:0] mem [256];
    logic       pre_en;
    logic [7:0] pre_a, pre_d;

    int n_cmp = 0;
    int n_err = 0;

    ram_sp_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_address(ram_address), .ram_data(ram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write (plus a bench preload port), asynchronous read onto the bus.
    always @(posedge clk) begin
        if (pre_en) mem[pre_a] <= pre_d;
        else if (ram_cs && ram_we) mem[ram_address] <= ram_data;
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? mem[ram_address] : 'z;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait (bounded) for ready, complete the handshake edge, drop valid.
    task automatic do_req(input bit n, input logic we, input logic [7:0] a, input logic [7:0] d);
        int w;
        w = 0;
        if (!n) begin
            req0_we = we; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
        end else begin
            req1_we = we; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
        end
        #1;
        while (!(n ? req1_ready : req0_ready) && w < 10) begin
            tick();
            w++;
        end
        chk("req_wait_bounded", 32'(w < 10), 32'd1);
        tick();
        if (!n) req0_valid = 1'b0;
        else    req1_valid = 1'b0;
    endtask

    initial begin
        int g, prevg;
        int viol, nreads;
        int age0, age1;
        logic lg_m, busy_m, gm, e0, e1;
        logic [7:0] exp0, exp1;
        logic [7:0] shadow [256];

        rst_n = 1'b0; pre_en = 1'b0; pre_a = '0; pre_d = '0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;

        // Reset for two cycles with req0 asking; preload the RAM meanwhile.
        #1;
        req0_valid = 1'b1;
        pre_en = 1'b1; pre_a = 8'h20; pre_d = 8'h11;
        tick();
        pre_a = 8'h21; pre_d = 8'h22;
        tick();
        pre_en = 1'b0;
        chk("rst_cs", 32'(ram_cs), 0);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_oe", 32'(ram_oe), 0);
        chk("rst_addr", 32'(ram_address), 0);
        chk("rst_ready0", 32'(req0_ready), 0);
        chk("rst_ready1", 32'(req1_ready), 0);
        chk("rst_rvalid", 32'({req0_rvalid, req1_rvalid}), 0);
        chk("rst_rdata", 32'({req0_rdata, req1_rdata}), 0);
        req0_valid = 1'b0;
        rst_n = 1'b1;

        // req0 write 10<-A5, then read it back; inputs scrambled after capture.
        req0_we = 1'b1; req0_addr = 8'h10; req0_wdata = 8'hA5; req0_valid = 1'b1;
        #1;
        chk("wr_ready0", 32'(req0_ready), 1);
        chk("wr_ready1", 32'(req1_ready), 0);
        tick();
        req0_valid = 1'b0; req0_addr = 8'hFF; req0_wdata = 8'h00;
        chk("wr_ctl", 32'({ram_cs, ram_we, ram_oe}), 32'b110);
        chk("wr_addr", 32'(ram_address), 32'h10);
        chk("wr_bus", 32'(ram_data), 32'hA5);
        chk("wr_ready_busy", 32'(req0_ready), 0);
        tick();
        chk("wr_gap_cs", 32'(ram_cs), 0);
        chk("wr_commit", 32'(mem[8'h10]), 32'hA5);
        req0_we = 1'b0; req0_addr = 8'h10; req0_valid = 1'b1;
        #1;
        chk("rd_ready0", 32'(req0_ready), 1);
        tick();
        req0_valid = 1'b0; req0_addr = 8'hFF;
        chk("rd_ctl", 32'({ram_cs, ram_we, ram_oe}), 32'b101);
        chk("rd_addr", 32'(ram_address), 32'h10);
        chk("rd_rvalid_early", 32'(req0_rvalid), 0);
        tick();
        chk("rd_rvalid0", 32'(req0_rvalid), 1);
        chk("rd_rdata0", 32'(req0_rdata), 32'hA5);
        chk("rd_gap_cs", 32'(ram_cs), 0);
        chk("rd_rvalid1", 32'(req1_rvalid), 0);
        tick();
        chk("rd_pulse_end", 32'(req0_rvalid), 0);
        chk("rd_hold", 32'(req0_rdata), 32'hA5);

        // Both valid continuously: req0 granted last, so order is 1,0,1,0,1,0.
        req0_we = 1'b1; req0_addr = 8'h01; req0_wdata = 8'h3C; req0_valid = 1'b1;
        req1_we = 1'b0; req1_addr = 8'h20; req1_valid = 1'b1;
        #1;
        g = 1; prevg = -1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                chk("rr_rvalid1", 32'(req1_rvalid), 32'(prevg == 1));
                if (prevg == 1) chk("rr_rdata1", 32'(req1_rdata), 32'h11);
            end
            chk("rr_ready0", 32'(req0_ready), 32'(g == 0));
            chk("rr_ready1", 32'(req1_ready), 32'(g == 1));
            tick();
            chk("rr_busy_ready", 32'({req0_ready, req1_ready}), 0);
            chk("rr_busy_cs", 32'(ram_cs), 1);
            tick();
            prevg = g;
            g = 1 - g;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_wr_commit", 32'(mem[8'h01]), 32'h3C);

        // req1 alone: two reads, req0 never answered.
        do_req(1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        chk("r1_rvalid_a", 32'(req1_rvalid), 1);
        chk("r1_rdata_a", 32'(req1_rdata), 32'h11);
        chk("r1_rvalid0_a", 32'(req0_rvalid), 0);
        do_req(1'b1, 1'b0, 8'h21, 8'h00);
        tick();
        chk("r1_rvalid_b", 32'(req1_rvalid), 1);
        chk("r1_rdata_b", 32'(req1_rdata), 32'h22);
        chk("r1_rvalid0_b", 32'(req0_rvalid), 0);

        // Reset on the edge ending WR: the write still lands.
        do_req(1'b0, 1'b1, 8'h30, 8'h5A);
        rst_n = 1'b0;
        tick();
        chk("rstwr_ctl", 32'({ram_cs, ram_we, ram_oe}), 0);
        chk("rstwr_commit", 32'(mem[8'h30]), 32'h5A);
        rst_n = 1'b1;
        do_req(1'b0, 1'b0, 8'h30, 8'h00);
        tick();
        chk("rstwr_readback", 32'(req0_rdata), 32'h5A);
        chk("rstwr_rvalid", 32'(req0_rvalid), 1);
        // Reset on the edge ending RD: read discarded.
        do_req(1'b0, 1'b0, 8'h30, 8'h00);
        rst_n = 1'b0;
        tick();
        chk("rstrd_rvalid", 32'(req0_rvalid), 0);
        chk("rstrd_rdata", 32'(req0_rdata), 0);
        rst_n = 1'b1;
        tick();
        chk("rstrd_rvalid_after", 32'(req0_rvalid), 0);

        // Random traffic against an independent grant/timing/data model.
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];
        lg_m = 1'b1; busy_m = 1'b0; age0 = 0; age1 = 0; viol = 0; nreads = 0;
        exp0 = '0; exp1 = '0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (ram_cs !== busy_m) viol++;
            if (ram_we && ram_oe) viol++;
            gm = (req0_valid && req1_valid) ? ~lg_m : req1_valid;
            e0 = !busy_m && req0_valid && !gm;
            e1 = !busy_m && req1_valid && gm;
            if (req0_ready !== e0 || req1_ready !== e1) viol++;
            if (req0_rvalid !== (age0 == 2)) viol++;
            if (req1_rvalid !== (age1 == 2)) viol++;
            if (age0 == 2 && req0_rvalid) begin chk("rnd_rdata0", 32'(req0_rdata), 32'(exp0)); nreads++; end
            if (age1 == 2 && req1_rvalid) begin chk("rnd_rdata1", 32'(req1_rdata), 32'(exp1)); nreads++; end
            @(posedge clk);
            #1;
            if (age0 == 2) age0 = 0; else if (age0 == 1) age0 = 2;
            if (age1 == 2) age1 = 0; else if (age1 == 1) age1 = 2;
            busy_m = e0 || e1;
            if (e0) begin
                lg_m = 1'b0;
                if (req0_we) shadow[req0_addr] = req0_wdata;
                else begin exp0 = shadow[req0_addr]; age0 = 1; end
                req0_valid = 1'b0;
            end
            if (e1) begin
                lg_m = 1'b1;
                if (req1_we) shadow[req1_addr] = req1_wdata;
                else begin exp1 = shadow[req1_addr]; age1 = 1; end
                req1_valid = 1'b0;
            end
            if (!req0_valid && $urandom_range(1, 0) == 1) begin
                req0_we = 1'($urandom_range(1, 0)); req0_addr = 8'($urandom_range(7, 0));
                req0_wdata = 8'($urandom_range(255, 0)); req0_valid = 1'b1;
            end
            if (!req1_valid && $urandom_range(1, 0) == 1) begin
                req1_we = 1'($urandom_range(1, 0)); req1_addr = 8'($urandom_range(7, 0));
                req1_wdata = 8'($urandom_range(255, 0)); req1_valid = 1'b1;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rnd_violations", 32'(viol), 0);
        chk("rnd_reads_seen", 32'(nreads > 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
